// File: rtl/obstacle_scheduler_if.sv
// Bundle between the game FSM / renderer and the obstacle scheduler.
// The master side drives the game controls and reads the obstacle picture.
// The slave side is the scheduler.
interface obstacle_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic                     i_tick;
  logic                     i_run;
  logic                     i_clear;
  logic [NUM_SLOTS-1:0]     o_slot_valid;
  logic [10*NUM_SLOTS-1:0]  o_slot_xpos;
  logic [4:0]               o_velocity;
  logic                     o_spawn_pulse;
  logic [7:0]               o_retire_count;

  modport master (
    output i_tick, i_run, i_clear,
    input  o_slot_valid, o_slot_xpos, o_velocity, o_spawn_pulse, o_retire_count
  );

  modport slave (
    input  i_tick, i_run, i_clear,
    output o_slot_valid, o_slot_xpos, o_velocity, o_spawn_pulse, o_retire_count
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler for the dinosaur game.
// Owns NUM_SLOTS obstacle slots, scrolls them left once per game tick, retires
// them past DESPAWN_X, spawns new ones at SPAWN_X after an LFSR-randomised gap,
// and ramps the shared scroll velocity as obstacles are retired.
module obstacle_scheduler #(
  parameter int          NUM_SLOTS  = 4,
  parameter int          SPAWN_X    = 800,
  parameter int          DESPAWN_X  = 150,
  parameter int          MIN_GAP    = 20,
  parameter int          V_INIT     = 6,
  parameter int          V_MAX      = 15,
  parameter int          RAMP_EVERY = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  obstacle_scheduler_if.slave   bus
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FREEZE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;

  logic [NUM_SLOTS-1:0] r_valid;
  logic [9:0]           r_xpos [NUM_SLOTS];
  logic [4:0]           r_velocity;
  logic                 r_spawnPulse;
  logic [7:0]           r_retireCount;
  logic [7:0]           r_gap;
  logic [7:0]           r_rampCnt;
  logic [15:0]          r_lfsr;

  logic [NUM_SLOTS-1:0] w_validNext;
  logic [9:0]           w_xposNext [NUM_SLOTS];
  logic [4:0]           w_velocityNext;
  logic                 w_spawnPulseNext;
  logic [7:0]           w_retireCountNext;
  logic [7:0]           w_gapNext;
  logic [7:0]           w_rampCntNext;
  logic [15:0]          w_lfsrNext;

  logic                 w_tickRun;
  logic [3:0]           w_nRetire;
  logic [7:0]           w_rampSum;
  logic                 w_freeFound;
  logic [IDX_W-1:0]     w_freeIdx;

  // A tick only does work while running, and a clear on the same cycle drops it.
  assign w_tickRun = (r_state == S_RUN) && bus.i_tick && !bus.i_clear;

  // Galois LFSR, taps 16/14/13/11; free-running so spawn gaps vary between games.
  assign w_lfsrNext = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // LFSR register: only the hard reset reseeds it, clear leaves it running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsrNext;
    end
  end

  // Game state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Game state transitions; clear wins over everything and returns to IDLE.
  always_comb begin
    w_stateNext = r_state;
    if (bus.i_clear) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.i_run)  w_stateNext = S_RUN;
        S_RUN:    if (!bus.i_run) w_stateNext = S_FREEZE;
        S_FREEZE: if (bus.i_run)  w_stateNext = S_RUN;
        default:  w_stateNext = S_IDLE;
      endcase
    end
  end

  // Per-tick slot movement, retirement, velocity ramp and spawning.
  always_comb begin
    w_validNext       = r_valid;
    w_xposNext        = r_xpos;
    w_velocityNext    = r_velocity;
    w_spawnPulseNext  = 1'b0;
    w_retireCountNext = r_retireCount;
    w_gapNext         = r_gap;
    w_rampCntNext     = r_rampCnt;
    w_nRetire         = 4'd0;
    w_rampSum         = 8'd0;
    w_freeFound       = 1'b0;
    w_freeIdx         = '0;

    // Lowest-index slot that is empty at tick start; a slot retiring on this
    // same tick is still valid here and therefore not reused until next tick.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_freeFound = 1'b1;
        w_freeIdx   = IDX_W'(i);
      end
    end

    if (bus.i_clear) begin
      w_validNext       = '0;
      w_xposNext        = '{default: '0};
      w_velocityNext    = 5'(V_INIT);
      w_retireCountNext = 8'd0;
      w_gapNext         = 8'(MIN_GAP);
      w_rampCntNext     = 8'd0;
    end else if (w_tickRun) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (r_valid[i]) begin
          if (r_xpos[i] <= 10'(DESPAWN_X)) begin
            w_validNext[i] = 1'b0;
            w_nRetire      = w_nRetire + 4'd1;
          end else begin
            w_xposNext[i] = r_xpos[i] - {5'd0, r_velocity};
          end
        end
      end

      w_retireCountNext = r_retireCount + {4'd0, w_nRetire};
      w_rampSum         = r_rampCnt + {4'd0, w_nRetire};
      if (w_nRetire != 4'd0) begin
        if (w_rampSum >= 8'(RAMP_EVERY)) begin
          w_rampCntNext  = 8'd0;
          w_velocityNext = (r_velocity == 5'(V_MAX)) ? 5'(V_INIT) : r_velocity + 5'd1;
        end else begin
          w_rampCntNext = w_rampSum;
        end
      end

      // With the gap expired and no free slot the spawn stays pending at gap 0.
      if (r_gap != 8'd0) begin
        w_gapNext = r_gap - 8'd1;
      end else if (w_freeFound) begin
        w_validNext[w_freeIdx] = 1'b1;
        w_xposNext[w_freeIdx]  = 10'(SPAWN_X);
        w_spawnPulseNext       = 1'b1;
        w_gapNext              = 8'(MIN_GAP) + {3'd0, r_lfsr[4:0]};
      end
    end
  end

  // Datapath registers; IDLE and FREEZE simply hold them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= '0;
      r_xpos        <= '{default: '0};
      r_velocity    <= 5'(V_INIT);
      r_spawnPulse  <= 1'b0;
      r_retireCount <= 8'd0;
      r_gap         <= 8'(MIN_GAP);
      r_rampCnt     <= 8'd0;
    end else begin
      r_valid       <= w_validNext;
      r_xpos        <= w_xposNext;
      r_velocity    <= w_velocityNext;
      r_spawnPulse  <= w_spawnPulseNext;
      r_retireCount <= w_retireCountNext;
      r_gap         <= w_gapNext;
      r_rampCnt     <= w_rampCntNext;
    end
  end

  assign bus.o_slot_valid   = r_valid;
  assign bus.o_velocity     = r_velocity;
  assign bus.o_spawn_pulse  = r_spawnPulse;
  assign bus.o_retire_count = r_retireCount;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_xposPack
    assign bus.o_slot_xpos[10*g +: 10] = r_xpos[g];
  end

endmodule
